// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: frequency-sweep sequencer for the PDM NCO 8-bit tuning word.
// A 4-byte profile (start, stop, step, dwell) is loaded over a valid/ready byte
// port. On go, freq_word steps from start to stop, each word held dwell+1
// cycles, in single-shot or repeat mode.
//
// Optional build macro NCO_SWEEP_TRIANGLE_EN: when defined, tri_en (sampled at
// go) adds a return leg from stop back to start; when undefined, tri_en is
// ignored and no triangle logic exists.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_data/valid    profile byte stream (start, stop, step, dwell)
//   cfg_ready         high when a byte can be accepted (IDLE/ARMED)
//   go, abort         start sweep / abandon sweep back to ARMED
//   repeat_en, tri_en sweep mode, both sampled at go
//   freq_word         tuning word to the NCO (0 outside RUN)
//   busy              high in RUN
//   done              one-cycle pulse at the end of each pass
module nco_sweep_ctrl #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       go,
    input  logic       abort,
    input  logic       repeat_en,
    input  logic       tri_en,
    output logic [7:0] freq_word,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t               state;
    logic [1:0]           byte_cnt;
    logic [7:0]           start_w;
    logic [7:0]           stop_w;
    logic [7:0]           step_w;
    logic [DWELL_W-1:0]   dwell_w;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic                 dir_up;
    logic                 rep_lat;

    logic                 byte_take;
    logic                 dwell_done;
    logic                 at_tgt;
    logic                 turn;
    logic [7:0]           next_word;
    logic [7:0]           rev_word;
    logic [7:0]           restart_word;
    logic [7:0]           leg_tgt;
    logic                 leg_up;

`ifdef NCO_SWEEP_TRIANGLE_EN
    logic                 tri_lat;
    logic                 leg;      // 0: toward stop, 1: return toward start
`else
    logic                 unused_tri_en;
    assign unused_tri_en = tri_en;
`endif

    // One step from cur toward tgt; zero step counts as 1, 9-bit math clamps at tgt.
    function automatic logic [7:0] step_word(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic       up,
                                             input logic [7:0] stp);
        logic [7:0] inc;
        logic [8:0] s;
        inc = (stp == 8'd0) ? 8'd1 : stp;
        if (up) begin
            s = {1'b0, cur} + {1'b0, inc};
            return (s >= {1'b0, tgt}) ? tgt : s[7:0];
        end
        s = {1'b0, cur} - {1'b0, inc};
        return (s[8] || (s[7:0] <= tgt)) ? tgt : s[7:0];
    endfunction

    assign byte_take = cfg_valid & cfg_ready;

    // Current-leg target and the candidate next words.
    always_comb begin
        leg_up       = dir_up;
        leg_tgt      = stop_w;
        turn         = 1'b0;
        rev_word     = 8'd0;
        restart_word = start_w;
`ifdef NCO_SWEEP_TRIANGLE_EN
        if (leg) begin
            leg_up  = ~dir_up;
            leg_tgt = start_w;
        end
        turn     = tri_lat & ~leg & (start_w != stop_w);
        rev_word = step_word(stop_w, start_w, ~dir_up, step_w);
        // A triangle repeat resumes one step past start, start was just held.
        if (tri_lat && (start_w != stop_w))
            restart_word = step_word(start_w, stop_w, dir_up, step_w);
`endif
        next_word  = step_word(freq_word, leg_tgt, leg_up, step_w);
        dwell_done = (dwell_cnt == dwell_w);
        at_tgt     = (freq_word == leg_tgt);
    end

    // Sequencer state, profile registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= 2'd0;
            start_w   <= 8'd0;
            stop_w    <= 8'd0;
            step_w    <= 8'd0;
            dwell_w   <= '0;
            dwell_cnt <= '0;
            dir_up    <= 1'b1;
            rep_lat   <= 1'b0;
            freq_word <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
`ifdef NCO_SWEEP_TRIANGLE_EN
            tri_lat   <= 1'b0;
            leg       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (byte_take) begin
                        case (byte_cnt)
                            2'd0:    start_w <= cfg_data;
                            2'd1:    stop_w  <= cfg_data;
                            2'd2:    step_w  <= cfg_data;
                            default: dwell_w <= DWELL_W'(cfg_data);
                        endcase
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            state <= ARMED;
                    end
                end
                ARMED: begin
                    // A byte in the same cycle as go starts a new profile; go is dropped.
                    if (byte_take) begin
                        start_w  <= cfg_data;
                        byte_cnt <= 2'd1;
                        state    <= IDLE;
                    end else if (go) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                        freq_word <= start_w;
                        dwell_cnt <= '0;
                        dir_up    <= (stop_w >= start_w);
                        rep_lat   <= repeat_en;
`ifdef NCO_SWEEP_TRIANGLE_EN
                        tri_lat   <= tri_en;
                        leg       <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= ARMED;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        freq_word <= 8'd0;
                    end else if (!dwell_done) begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end else begin
                        dwell_cnt <= '0;
                        if (!at_tgt) begin
                            freq_word <= next_word;
                        end else if (turn) begin
                            freq_word <= rev_word;
`ifdef NCO_SWEEP_TRIANGLE_EN
                            leg       <= 1'b1;
`endif
                        end else begin
                            done <= 1'b1;
`ifdef NCO_SWEEP_TRIANGLE_EN
                            leg  <= 1'b0;
`endif
                            if (rep_lat) begin
                                freq_word <= restart_word;
                            end else begin
                                state     <= ARMED;
                                busy      <= 1'b0;
                                cfg_ready <= 1'b1;
                                freq_word <= 8'd0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Randomized bench for nco_sweep_ctrl: a list-based reference model expands
// each profile into the per-cycle word sequence expected at freq_word.
module tb_nco_sweep_ctrl;

`ifdef NCO_SWEEP_TRIANGLE_EN
    localparam bit TRI_BUILD = 1'b1;
`else
    localparam bit TRI_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       go;
    logic       abort;
    logic       repeat_en;
    logic       tri_en;
    logic [7:0] freq_word;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    nco_sweep_ctrl #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .go        (go),
        .abort     (abort),
        .repeat_en (repeat_en),
        .tri_en    (tri_en),
        .freq_word (freq_word),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int w, input int b, input int d, input int r);
        check({tag, ".freq_word"}, int'(freq_word), w);
        check({tag, ".busy"},      int'(busy),      b);
        check({tag, ".done"},      int'(done),      d);
        check({tag, ".cfg_ready"}, int'(cfg_ready), r);
    endtask

    task automatic send_byte(input int b);
        repeat ($urandom_range(0, 2)) tick();
        cfg_valid = 1'b1;
        cfg_data  = 8'(b);
        tick();
        cfg_valid = 1'b0;
    endtask

    // One clamped step from w toward t.
    function automatic int step_toward(input int w, input int t, input int inc);
        if (t > w) return (w + inc >= t) ? t : w + inc;
        return (w - inc <= t) ? t : w - inc;
    endfunction

    // sel: 0 no abort (random if repeating), 1 random abort, 2 abort on last cycle.
    task automatic do_sweep(input int s, input int e, input int st, input int dw,
                            input bit rep, input bit tri_mode, input int sel, input bit load);
        int  path[$];
        int  words[$];
        bit  dn[$];
        int  inc, w, n, ab, passes;
        bit  tri_act;
        inc = (st == 0) ? 1 : st;
        w = s;
        path.push_back(w);
        while (w != e) begin
            w = step_toward(w, e, inc);
            path.push_back(w);
        end
        tri_act = TRI_BUILD && tri_mode && (s != e);
        if (tri_act) begin
            w = e;
            while (w != s) begin
                w = step_toward(w, s, inc);
                path.push_back(w);
            end
        end
        passes = rep ? 3 : 1;
        for (int p = 0; p < passes; p++) begin
            bit first;
            first = (p > 0);
            for (int j = 0; j < path.size(); j++) begin
                if (p > 0 && tri_act && j == 0) continue;
                for (int k = 0; k <= dw; k++) begin
                    words.push_back(path[j]);
                    dn.push_back(first);
                    first = 1'b0;
                end
            end
        end

        if (load) begin
            send_byte(s); send_byte(e); send_byte(st); send_byte(dw);
        end else begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_out("abort_armed", 0, 0, 0, 1);
        end
        go = 1'b1; repeat_en = rep; tri_en = tri_mode;
        tick();
        go = 1'b0; repeat_en = 1'($urandom); tri_en = 1'($urandom);

        n  = words.size();
        ab = -1;
        if (rep || sel == 1) ab = int'($urandom_range(0, n - 1));
        else if (sel == 2)   ab = n - 1;
        for (int i = 0; i < n; i++) begin
            check_out("run", words[i], 1, int'(dn[i]), 0);
            if (i == ab) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check_out("abort", 0, 0, 0, 1);
                return;
            end
            if (i < n - 1) begin
                cfg_valid = 1'($urandom);
                cfg_data  = 8'($urandom);
                go        = 1'($urandom);
            end
            tick();
            cfg_valid = 1'b0;
            go        = 1'b0;
        end
        check_out("end_pass", 0, 0, 1, 1);
        tick();
        check_out("after_pass", 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; cfg_data = 8'd0; cfg_valid = 1'b0; go = 1'b0;
        abort = 1'b0; repeat_en = 1'b0; tri_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_out("reset", 0, 0, 0, 1);

        // Directed profiles.
        do_sweep(10, 16, 3, 1, 1'b0, 1'b0, 0, 1'b1);
        do_sweep(10, 16, 3, 1, 1'b0, 1'b0, 0, 1'b0);   // replay kept profile
        do_sweep(200, 250, 40, 0, 1'b0, 1'b0, 0, 1'b1);
        do_sweep(5, 1, 3, 0, 1'b0, 1'b0, 0, 1'b1);
        do_sweep(0, 4, 0, 0, 1'b1, 1'b0, 0, 1'b1);
        do_sweep(10, 14, 2, 0, 1'b0, 1'b1, 0, 1'b1);
        do_sweep(10, 14, 2, 0, 1'b1, 1'b1, 0, 1'b0);
        do_sweep(77, 77, 5, 2, 1'b0, 1'b0, 0, 1'b1);
        do_sweep(3, 9, 2, 0, 1'b0, 1'b0, 2, 1'b1);     // abort beats end of pass

        // go ignored in IDLE; byte beats go in ARMED.
        send_byte(1); send_byte(2);
        repeat (5) tick();
        go = 1'b1; tick(); go = 1'b0;
        check_out("idle_go", 0, 0, 0, 1);
        send_byte(3); send_byte(0);
        cfg_valid = 1'b1; cfg_data = 8'd7; go = 1'b1;
        tick();
        cfg_valid = 1'b0; go = 1'b0;
        check_out("byte_beats_go", 0, 0, 0, 1);
        go = 1'b1; tick(); go = 1'b0;
        check_out("idle_after_byte", 0, 0, 0, 1);
        send_byte(19); send_byte(4); send_byte(0);
        do_sweep(7, 19, 4, 0, 1'b0, 1'b0, 0, 1'b0);

        // Reset mid-sweep.
        send_byte(20); send_byte(40); send_byte(5); send_byte(3);
        go = 1'b1; tick(); go = 1'b0;
        check_out("hold1", 20, 1, 0, 0);
        tick();
        check_out("hold2", 20, 1, 0, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check_out("mid_rst", 0, 0, 0, 1);
        go = 1'b1; tick(); go = 1'b0;
        check_out("rst_go", 0, 0, 0, 1);
        tick();
        check_out("rst_go2", 0, 0, 0, 1);

        // Randomized profiles.
        for (int k = 0; k < 16; k++) begin
            int s, e;
            s = int'($urandom_range(0, 255));
            e = (k % 3 == 0) ? int'($urandom_range(0, 255))
                             : (s + int'($urandom_range(0, 60)) - 30) & 255;
            do_sweep(s, e, int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
                     1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b1);
            if (k % 4 == 1)
                do_sweep(s, e, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
